// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch/register-file slice.
// Covers the ALU operation codes, the main-control alu_op classes,
// the R-type funct values and the default reset PC.
// Also provides the branch-offset helper used by the next-PC logic.
package mips_pkg;

    // ALU operation codes driven to the ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // alu_op classes produced by main control
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extended word offset of a branch: sext(imm) << 2
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_regs_if.sv
// Signal bundle between the fetch/register slice and its neighbours:
// instruction memory, main control, the ALU and the write-back mux.
// master = the surrounding datapath; slave = mips_fetch_regs.
interface mips_fetch_regs_if;

    logic [31:0] instr;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [3:0]  operation;
    logic        jr;
    logic        rf_write;

    modport master (
        output instr, branch, jump, zero, alu_op, reg_write, wr_addr, wr_data,
        input  pc, pcplus4, rd_data1, rd_data2, operation, jr, rf_write
    );

    modport slave (
        input  instr, branch, jump, zero, alu_op, reg_write, wr_addr, wr_data,
        output pc, pcplus4, rd_data1, rd_data2, operation, jr, rf_write
    );

endinterface

// File: rtl/mips_alu_ctrl.sv
// ALU control decode: maps the main-control alu_op class, and for R-type
// the funct field, onto a 4-bit ALU operation code. It also flags jr.
// Any unknown combination falls back to ADD.
module mips_alu_ctrl
    import mips_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] operation_o,
    output logic       jr_o
);

    // Decode alu_op/funct into the ALU operation and the jr flag
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        operation_o = ALU_ADD;
        jr_o        = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: operation_o = ALU_ADD;
            ALUOP_SUB: operation_o = ALU_SUB;
            ALUOP_AND: operation_o = ALU_AND;
            ALUOP_OR:  operation_o = ALU_OR;
            ALUOP_SLT: operation_o = ALU_SLT;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: operation_o = ALU_ADD;
                    FUNCT_SUB: operation_o = ALU_SUB;
                    FUNCT_AND: operation_o = ALU_AND;
                    FUNCT_OR:  operation_o = ALU_OR;
                    FUNCT_NOR: operation_o = ALU_NOR;
                    FUNCT_SLT: operation_o = ALU_SLT;
                    FUNCT_SLL: operation_o = ALU_SLL;
                    FUNCT_SRL: operation_o = ALU_SRL;
                    FUNCT_JR: begin
                        operation_o = ALU_ADD;
                        jr_o        = 1'b1;
                    end
                    default:   operation_o = ALU_ADD;
                endcase
            end
            default: operation_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_fetch_regs.sv
// Single-cycle MIPS core slice: PC register with next-PC select,
// 32x32 register file (2 async reads, 1 sync write), and ALU-control decode.
// A jr instruction steers the next PC to rd_data1 and suppresses the RF write.
// Optional feature: define RF_BYPASS_EN to make a read of the register being
// written in the same cycle return wr_data (write-through) instead of the old value.
module mips_fetch_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DATA_W   = 32
) (
    input logic               clk,
    input logic               rst_n,
    mips_fetch_regs_if.slave  bus
);

    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic [31:0]       pcplus4;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [3:0]        operation;
    logic              jr;
    logic              rf_write;

    mips_alu_ctrl u_alu_ctrl (
        .alu_op_i    (bus.alu_op),
        .funct_i     (bus.instr[5:0]),
        .operation_o (operation),
        .jr_o        (jr)
    );

    assign rf_write = bus.reg_write & ~jr;
    assign pcplus4  = pc_q + 32'd4;

    // Next-PC select: jr, then jump, then taken branch, else sequential
    always_comb begin
        pc_d = pcplus4;
        if (jr) begin
            pc_d = rd1;
        end else if (bus.jump) begin
            pc_d = {pcplus4[31:28], bus.instr[25:0], 2'b00};
        end else if (bus.branch && bus.zero) begin
            pc_d = pcplus4 + branch_offset(bus.instr[15:0]);
        end
    end

    // PC register, loaded every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Register file write port; register 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_write && (bus.wr_addr != 5'd0)) begin
            rf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read port 1 (rs): register 0 reads zero
    always_comb begin
        rd1 = '0;
        if (bus.instr[25:21] != 5'd0) begin
            rd1 = rf_q[bus.instr[25:21]];
        end
`ifdef RF_BYPASS_EN
        if (rf_write && (bus.wr_addr != 5'd0) && (bus.wr_addr == bus.instr[25:21])) begin
            rd1 = bus.wr_data;
        end
`endif
    end

    // Read port 2 (rt): register 0 reads zero
    always_comb begin
        rd2 = '0;
        if (bus.instr[20:16] != 5'd0) begin
            rd2 = rf_q[bus.instr[20:16]];
        end
`ifdef RF_BYPASS_EN
        if (rf_write && (bus.wr_addr != 5'd0) && (bus.wr_addr == bus.instr[20:16])) begin
            rd2 = bus.wr_data;
        end
`endif
    end

    assign bus.pc        = pc_q;
    assign bus.pcplus4   = pcplus4;
    assign bus.rd_data1  = rd1;
    assign bus.rd_data2  = rd2;
    assign bus.operation = operation;
    assign bus.jr        = jr;
    assign bus.rf_write  = rf_write;

endmodule

// File: tb/tb_mips_fetch_regs.sv
// Self-checking bench for mips_fetch_regs: a table of ALU-control vectors
// plus hand-written sequences for reset, RF write/read, branch, jump, jr
// and PC wrap. Expected PCs go into a queue as each cycle is set up and are
// popped and compared once the clock edge has produced the new PC.
module tb_mips_fetch_regs;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mips_fetch_regs_if bus ();

    mips_fetch_regs dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] alu_op;
        logic [5:0] funct;
        logic [3:0] exp_op;
        logic       exp_jr;
    } alu_vec_t;

    alu_vec_t    vecs[$];
    logic [31:0] exp_pc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_EXP = 32'hCAFE_F00D;
`else
    localparam logic [31:0] SAME_CYCLE_EXP = 32'hDEAD_BEEF;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Push the expected PC, clock once, then pop and compare it
    task automatic tick(input logic [31:0] exp_pc);
        logic [31:0] e;
        exp_pc_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        e = exp_pc_q.pop_front();
        check("pc_after_edge", bus.pc, e);
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [5:0] funct);
        return {6'd0, rs, rt, 5'd0, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {6'b000100, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [25:0] target);
        return {6'b000010, target};
    endfunction

    task automatic idle_inputs();
        bus.branch    = 1'b0;
        bus.jump      = 1'b0;
        bus.zero      = 1'b0;
        bus.alu_op    = ALUOP_ADD;
        bus.reg_write = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'd0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.instr = 32'd0;
        idle_inputs();

        vecs.push_back('{ALUOP_ADD,   6'b000000, 4'b0010, 1'b0});
        vecs.push_back('{ALUOP_SUB,   6'b000000, 4'b0110, 1'b0});
        vecs.push_back('{ALUOP_AND,   6'b000000, 4'b0000, 1'b0});
        vecs.push_back('{ALUOP_OR,    6'b000000, 4'b0001, 1'b0});
        vecs.push_back('{ALUOP_SLT,   6'b000000, 4'b0111, 1'b0});
        vecs.push_back('{3'b110,      6'b100010, 4'b0010, 1'b0});
        vecs.push_back('{3'b111,      6'b100010, 4'b0010, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b100000, 4'b0010, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b100010, 4'b0110, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b100100, 4'b0000, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b100101, 4'b0001, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b100111, 4'b1100, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b101010, 4'b0111, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b000000, 4'b0011, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b000010, 4'b0100, 1'b0});
        vecs.push_back('{ALUOP_RTYPE, 6'b001000, 4'b0010, 1'b1});
        vecs.push_back('{ALUOP_RTYPE, 6'b111111, 4'b0010, 1'b0});
        vecs.push_back('{ALUOP_SUB,   6'b001000, 4'b0110, 1'b0});

        // ALU control sweep, held in reset so the PC and RF stay put
        #1;
        check("pc_in_reset", bus.pc, 32'h0);
        bus.reg_write = 1'b1;
        foreach (vecs[i]) begin
            bus.alu_op = vecs[i].alu_op;
            bus.instr  = mk_r(5'd0, 5'd0, vecs[i].funct);
            #1;
            check($sformatf("op alu_op=%b funct=%b", vecs[i].alu_op, vecs[i].funct),
                  {28'd0, bus.operation}, {28'd0, vecs[i].exp_op});
            check($sformatf("jr alu_op=%b funct=%b", vecs[i].alu_op, vecs[i].funct),
                  {31'd0, bus.jr}, {31'd0, vecs[i].exp_jr});
            check($sformatf("rf_write alu_op=%b funct=%b", vecs[i].alu_op, vecs[i].funct),
                  {31'd0, bus.rf_write}, {31'd0, ~vecs[i].exp_jr});
        end
        idle_inputs();
        bus.instr = 32'd0;

        // Leave reset, put something in RF[7], advance the PC
        @(negedge clk);
        rst_n         = 1'b1;
        bus.instr     = mk_r(5'd7, 5'd0, FUNCT_ADD);
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd7;
        bus.wr_data   = 32'hA5A5_A5A5;
        tick(32'h4);
        bus.reg_write = 1'b0;
        check("rf7_before_reset", bus.rd_data1, 32'hA5A5_A5A5);
        tick(32'h8);

        // Mid-cycle asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        check("pc_async_reset", bus.pc, 32'h0);
        check("pcplus4_in_reset", bus.pcplus4, 32'h4);
        check("rf7_cleared", bus.rd_data1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(32'h4);
        tick(32'h8);
        tick(32'hC);

        // RF write then read on both ports
        bus.instr     = mk_r(5'd5, 5'd5, FUNCT_ADD);
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd5;
        bus.wr_data   = 32'hDEAD_BEEF;
        tick(32'h10);
        bus.reg_write = 1'b0;
        check("rf5_rd1", bus.rd_data1, 32'hDEAD_BEEF);
        check("rf5_rd2", bus.rd_data2, 32'hDEAD_BEEF);

        // Write to register 0 is dropped
        bus.instr     = mk_r(5'd0, 5'd0, FUNCT_ADD);
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd0;
        bus.wr_data   = 32'h0000_1234;
        tick(32'h14);
        bus.reg_write = 1'b0;
        check("rf0_reads_zero", bus.rd_data1, 32'h0);

        // Same-cycle read of the register being written
        bus.instr     = mk_r(5'd5, 5'd0, FUNCT_ADD);
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd5;
        bus.wr_data   = 32'hCAFE_F00D;
        #1;
        check("rf5_same_cycle", bus.rd_data1, SAME_CYCLE_EXP);
        tick(32'h18);
        bus.reg_write = 1'b0;
        check("rf5_after_write", bus.rd_data1, 32'hCAFE_F00D);

        // Jump/jr targets for later
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd31;
        bus.wr_data   = 32'h0000_0200;
        tick(32'h1C);
        bus.wr_addr   = 5'd30;
        bus.wr_data   = 32'hFFFF_FFFC;
        tick(32'h20);
        bus.reg_write = 1'b0;

        // Jump back to 0x10
        bus.instr = mk_j(26'h4);
        bus.jump  = 1'b1;
        tick(32'h10);
        bus.jump  = 1'b0;

        // Branch taken with negative offset: 0x10 -> 0x0C
        bus.instr  = mk_i(5'd0, 5'd0, 16'hFFFE);
        bus.branch = 1'b1;
        bus.zero   = 1'b1;
        tick(32'hC);
        bus.branch = 1'b0;
        bus.zero   = 1'b0;
        tick(32'h10);
        // Branch not taken
        bus.branch = 1'b1;
        tick(32'h14);
        bus.branch = 1'b0;

        // Jump to target 0x40
        bus.instr = mk_j(26'h40);
        bus.jump  = 1'b1;
        tick(32'h100);

        // jr through RF[31], with jump also set and a write request pending
        bus.instr     = mk_r(5'd31, 5'd0, FUNCT_JR);
        bus.alu_op    = ALUOP_RTYPE;
        bus.reg_write = 1'b1;
        bus.wr_addr   = 5'd5;
        bus.wr_data   = 32'h0000_0BAD;
        #1;
        check("jr_flag", {31'd0, bus.jr}, 32'd1);
        check("jr_operation", {28'd0, bus.operation}, {28'd0, ALU_ADD});
        check("jr_rf_write", {31'd0, bus.rf_write}, 32'd0);
        check("jr_rd1", bus.rd_data1, 32'h200);
        tick(32'h200);
        idle_inputs();
        bus.instr = mk_r(5'd5, 5'd0, FUNCT_ADD);
        #1;
        check("rf5_not_written_by_jr", bus.rd_data1, 32'hCAFE_F00D);

        // jr to the top word, then PC wraps to 0
        bus.instr  = mk_r(5'd30, 5'd0, FUNCT_JR);
        bus.alu_op = ALUOP_RTYPE;
        tick(32'hFFFF_FFFC);
        bus.alu_op = ALUOP_ADD;
        bus.instr  = 32'd0;
        #1;
        check("pcplus4_wrap", bus.pcplus4, 32'h0);
        tick(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
